// File: rtl/dcount_pkg.sv
// Shared types and constants for the counter checker.
// Holds the FSM state encoding, default parameters and the LFSR constants.
package dcount_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_SEED,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_STEP  = 1;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1 taps bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

endpackage

// File: rtl/dcount_lfsr.sv
// 16-bit LFSR producing the pseudo-random stall pattern for the counter enable.
// Only instantiated when DCOUNT_CHECKER_STALL_EN is defined.
module dcount_lfsr
  import dcount_pkg::*;
(
  input  logic clock,
  input  logic rst,
  input  logic enable,
  output logic lfsr_bit
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (enable) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_bit = lfsr_q[0];

endmodule

// File: rtl/dcount_checker.sv
// Drives a counter's enable and checks that its output steps by STEP each enabled cycle.
// Define DCOUNT_CHECKER_STALL_EN to stall the counter pseudo-randomly during RUN.
module dcount_checker
  import dcount_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int NUM_SAMPLES = 1024,
  parameter int STEP        = DEFAULT_STEP
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             start,
  input  logic             rdy,
  input  logic [WIDTH-1:0] d_out,
  output logic             d_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             aborted,
  output logic [15:0]      err_count,
  output logic [WIDTH-1:0] last_bad
);

  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
  localparam logic [15:0]      LAST_IDX = 16'(NUM_SAMPLES - 1);

  state_e           state_q, state_d;
  logic             d_en_q, d_en_d;
  logic             d_en_prev_q;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [15:0]      sample_cnt_q, sample_cnt_d;
  logic [15:0]      err_count_q, err_count_d;
  logic [WIDTH-1:0] last_bad_q, last_bad_d;
  logic             pass_q, pass_d;
  logic             aborted_q, aborted_d;
  logic             mismatch;
  logic [WIDTH-1:0] base;
  logic             run_en;

`ifdef DCOUNT_CHECKER_STALL_EN
  logic lfsr_bit;

  dcount_lfsr u_lfsr (
    .clock    (clock),
    .rst      (rst),
    .enable   (state_q == ST_RUN),
    .lfsr_bit (lfsr_bit)
  );

  assign run_en = lfsr_bit;
`else
  assign run_en = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    d_en_d       = 1'b0;
    expected_d   = expected_q;
    sample_cnt_d = sample_cnt_q;
    err_count_d  = err_count_q;
    last_bad_d   = last_bad_q;
    pass_d       = pass_q;
    aborted_d    = aborted_q;
    mismatch     = (d_out != expected_q);
    // On a mismatch the reference follows the counter so one glitch is one error
    base         = mismatch ? d_out : expected_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_WAIT_RDY;
          err_count_d = '0;
          last_bad_d  = '0;
          pass_d      = 1'b0;
          aborted_d   = 1'b0;
        end
      end
      ST_WAIT_RDY: begin
        if (rdy) begin
          state_d = ST_SEED;
          d_en_d  = 1'b1;
        end
      end
      ST_SEED: begin
        expected_d   = d_out + STEP_W;
        sample_cnt_d = '0;
        state_d      = ST_RUN;
        d_en_d       = run_en;
      end
      ST_RUN: begin
        if (!rdy) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
          pass_d    = 1'b0;
        end else begin
          expected_d = d_en_q ? (base + STEP_W) : base;
          if (mismatch) begin
            err_count_d = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;
            last_bad_d  = d_out;
          end
          d_en_d = run_en;
          if (d_en_prev_q) begin
            sample_cnt_d = sample_cnt_q + 16'd1;
            if (sample_cnt_q == LAST_IDX) begin
              state_d = ST_DONE;
              d_en_d  = 1'b0;
              pass_d  = !mismatch && (err_count_q == 16'd0);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      d_en_q       <= 1'b0;
      d_en_prev_q  <= 1'b0;
      expected_q   <= '0;
      sample_cnt_q <= '0;
      err_count_q  <= '0;
      last_bad_q   <= '0;
      pass_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      d_en_q       <= d_en_d;
      d_en_prev_q  <= d_en_q;
      expected_q   <= expected_d;
      sample_cnt_q <= sample_cnt_d;
      err_count_q  <= err_count_d;
      last_bad_q   <= last_bad_d;
      pass_q       <= pass_d;
      aborted_q    <= aborted_d;
    end
  end

  assign d_en      = d_en_q;
  assign busy      = (state_q == ST_WAIT_RDY) || (state_q == ST_SEED) || (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign aborted   = aborted_q;
  assign err_count = err_count_q;
  assign last_bad  = last_bad_q;

endmodule

// File: tb/tb_dcount_checker.sv
// Directed bench for dcount_checker driving a behavioural counter that honours d_en.
// Works with or without DCOUNT_CHECKER_STALL_EN defined.
module tb_dcount_checker;

  localparam int NS = 8;

  logic        clock;
  logic        rst;
  logic        start;
  logic        rdy;
  logic [15:0] d_out;
  logic        d_en;
  logic        busy;
  logic        done;
  logic        pass;
  logic        aborted;
  logic [15:0] err_count;
  logic [15:0] last_bad;

  int          n_compared;
  int          n_mismatched;
  logic [15:0] cnt;
  logic        glitch_en;
  logic [15:0] glitch_from;
  logic [15:0] glitch_to;
  int          en_cycles;
  int          counted;
  logic        finished;

  dcount_checker #(
    .WIDTH       (16),
    .NUM_SAMPLES (NS),
    .STEP        (1)
  ) dut (
    .clock     (clock),
    .rst       (rst),
    .start     (start),
    .rdy       (rdy),
    .d_out     (d_out),
    .d_en      (d_en),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .aborted   (aborted),
    .err_count (err_count),
    .last_bad  (last_bad)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock of the behavioural counter: it advances on edges where d_en was high
  task automatic tick();
    logic en;
    en = d_en;
    @(posedge clock);
    #1;
    if (en) begin
      en_cycles++;
      cnt = cnt + 16'd1;
      if (glitch_en && cnt == glitch_from) begin
        cnt       = glitch_to;
        glitch_en = 1'b0;
      end
      if (busy) counted++;
    end
    d_out = cnt;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_d_en"}, d_en, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_pass"}, pass, 0);
    checkOutput({tag, "_aborted"}, aborted, 0);
    checkOutput({tag, "_err_count"}, err_count, 0);
    checkOutput({tag, "_last_bad"}, last_bad, 0);
  endtask

  // Runs one start..done sequence; abort_at/rst_at/start_at name a RUN cycle (0 = never)
  task automatic applyStimulus(input logic [15:0] seed, input int abort_at,
                               input int rst_at, input int start_at);
    en_cycles = 0;
    counted   = 0;
    finished  = 1'b0;
    cnt       = seed;
    d_out     = seed;
    rdy       = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rdy = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      tick();
      start = 1'b0;
      if (done) begin
        finished = 1'b1;
        break;
      end
      if (start_at > 0 && counted == start_at) start = 1'b1;
      if (abort_at > 0 && counted == abort_at) rdy = 1'b0;
      if (rst_at > 0 && counted == rst_at) begin
        rst = 1'b0;
        #1;
        checkAllZero("midrun_rst");
        @(posedge clock);
        #3;
        rst = 1'b1;
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!finished) checkOutput("run_timeout", 0, 1);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    glitch_en    = 1'b0;
    glitch_from  = 16'h0;
    glitch_to    = 16'h0;
    cnt          = 16'h0;
    rst          = 1'b0;
    start        = 1'b0;
    rdy          = 1'b0;
    d_out        = 16'h0;
    repeat (2) @(posedge clock);
    #1;
    checkAllZero("reset");
    rst = 1'b1;
    tick();

    // Conforming counter from 0x0010
    applyStimulus(16'h0010, 0, 0, 0);
    checkOutput("t1_done", done, 1);
    checkOutput("t1_pass", pass, 1);
    checkOutput("t1_err_count", err_count, 0);
    checkOutput("t1_counted", counted, NS);
`ifndef DCOUNT_CHECKER_STALL_EN
    checkOutput("t1_en_cycles", en_cycles, NS + 1);
`endif
    tick();
    checkOutput("t1_d_en_low", d_en, 0);
    checkOutput("t1_done_held", done, 1);

    // Wrap through 0x0000
    applyStimulus(16'hFFFC, 0, 0, 0);
    checkOutput("t2_pass", pass, 1);
    checkOutput("t2_err_count", err_count, 0);
    checkOutput("t2_counted", counted, NS);

    // Counter jumps to 0x1234 where 0x0020 was expected, then continues from there
    glitch_en   = 1'b1;
    glitch_from = 16'h0020;
    glitch_to   = 16'h1234;
    applyStimulus(16'h001C, 0, 0, 0);
    checkOutput("t3_done", done, 1);
    checkOutput("t3_err_count", err_count, 1);
    checkOutput("t3_last_bad", last_bad, 16'h1234);
    checkOutput("t3_pass", pass, 0);

    // rdy dropped on the 4th RUN cycle; statistics from the previous run must be cleared
    applyStimulus(16'h0040, 4, 0, 0);
    checkOutput("t4_aborted", aborted, 1);
    checkOutput("t4_pass", pass, 0);
    checkOutput("t4_done", done, 1);
    checkOutput("t4_d_en", d_en, 0);
    checkOutput("t4_err_count", err_count, 0);
    checkOutput("t4_last_bad", last_bad, 0);

    // Reset mid-run, then a clean run with a stray start pulse during RUN
    applyStimulus(16'h0080, 0, 3, 0);
    applyStimulus(16'h0100, 0, 0, 2);
    checkOutput("t5_done", done, 1);
    checkOutput("t5_pass", pass, 1);
    checkOutput("t5_aborted", aborted, 0);
    checkOutput("t5_err_count", err_count, 0);
    checkOutput("t5_counted", counted, NS);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/dcount_checker.md
DCOUNT_CHECKER -- requirements
Module: dcount_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 16: width of the counter value under test.
REQ-002 SHALL have parameter NUM_SAMPLES, default 1024: number of comparisons per run (1..65535).
REQ-003 SHALL have parameter STEP, default 1: expected increment per enabled cycle, modulo 2^WIDTH.
REQ-004 SHALL have ports: clock  in  1  single clock; all state on rising edge.
REQ-005 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: start  in  1  one-cycle pulse that begins a run.
REQ-007 SHALL have ports: rdy  in  1  counter ready indication.
REQ-008 SHALL have ports: d_out  in  WIDTH  counter value being checked.
REQ-009 SHALL have ports: d_en  out  1  registered enable driven to the counter.
REQ-010 SHALL have ports: busy  out  1  high in WAIT_RDY, SEED and RUN.
REQ-011 SHALL have ports: done  out  1  high while in DONE.
REQ-012 SHALL have ports: pass  out  1  valid when done; high iff zero errors and no abort.
REQ-013 SHALL have ports: aborted  out  1  rdy fell during RUN.
REQ-014 SHALL have ports: err_count  out  16  mismatch count, saturating.
REQ-015 SHALL have ports: last_bad  out  WIDTH  d_out value of the most recent mismatch.

Function
REQ-016 SHALL implement the FSM IDLE -> WAIT_RDY -> SEED -> RUN -> DONE.
- IDLE -> WAIT_RDY on start.
- WAIT_RDY -> SEED when rdy=1.
- SEED -> RUN after exactly 1 cycle.
- RUN -> DONE when NUM_SAMPLES comparisons complete, or when rdy=0 (abort).
REQ-017 SHALL hold d_en=0 in IDLE, WAIT_RDY and DONE, and set d_en=1 (registered) from the SEED cycle through RUN.
REQ-018 SHALL, in SEED, capture d_out into expected = d_out + STEP; no comparison occurs in SEED.
REQ-019 SHALL, in each RUN cycle following a cycle with d_en=1, compare d_out with expected and then advance expected by STEP; in a RUN cycle following d_en=0, compare against the held expected value without advancing it.
REQ-020 SHALL, on mismatch, increment err_count (saturating at 0xFFFF), load last_bad with d_out, and resynchronise expected to d_out + STEP, so that a single glitch counts as one error.
REQ-021 SHALL wrap expected modulo 2^WIDTH; a transition from 0xFFFF to 0x0000 is not an error.
REQ-022 SHALL drop d_en in the same cycle it enters DONE; the final comparison is the NUM_SAMPLES-th.
REQ-023 SHALL, on an abort, set aborted=1 and pass=0, and perform no comparison in the cycle in which rdy is seen low.
REQ-024 SHALL ignore start in WAIT_RDY, SEED and RUN.
REQ-025 SHALL, on start in DONE, clear err_count, last_bad, aborted and pass, and enter WAIT_RDY.
REQ-026 SHALL give priority to the abort when rdy falls in the same cycle as the final comparison.

Reset
REQ-027 SHALL, on rst=0, asynchronously force state=IDLE, d_en=0, busy=0, done=0, pass=0, aborted=0, err_count=0, last_bad=0, expected=0 and the sample counter to 0.
REQ-028 SHALL restart cleanly in IDLE when rst is asserted mid-run, with no residual statistics.

Configuration
REQ-029 SHALL, when DCOUNT_CHECKER_STALL_EN is defined, drive d_en in RUN from bit 0 of a 16-bit LFSR (seed 0xACE1, polynomial x^16+x^14+x^13+x^11+1), so that the counter stalls pseudo-randomly; only cycles following d_en=1 count toward NUM_SAMPLES.
REQ-030 SHALL, when DCOUNT_CHECKER_STALL_EN is undefined, hold d_en constant at 1 throughout RUN, omit the LFSR entirely, and make every RUN cycle a counted comparison.

Structure
REQ-031 SHALL take the state enumeration type, the default WIDTH and STEP values, and the LFSR seed/tap constants from shared package dcount_pkg.
REQ-032 SHALL place the LFSR in sub-module dcount_lfsr, instantiated only under DCOUNT_CHECKER_STALL_EN.

Verification
REQ-033 SHALL cover: reset, start, rdy high after 3 cycles, with a conforming counter from 0x0010 and NUM_SAMPLES=8 -> d_en high for 9 cycles, done=1, pass=1, err_count=0.
REQ-034 SHALL cover: a counter seeded at 0xFFFC over 8 samples -> wrap through 0x0000 yields pass=1, err_count=0.
REQ-035 SHALL cover: a single injected d_out value of 0x1234 where 0x0020 is expected -> err_count=1, last_bad=0x1234, later samples matching, pass=0.
REQ-036 SHALL cover: rdy dropped on the 4th RUN cycle -> aborted=1, pass=0, done=1, d_en=0 on the next edge.
REQ-037 SHALL cover: rst pulsed low mid-RUN -> all outputs zero immediately; a later start yields a clean, passing run.
REQ-038 SHALL cover, with DCOUNT_CHECKER_STALL_EN defined: a counter honouring d_en -> pass=1, with the number of counted comparisons equal to NUM_SAMPLES despite the stalls.
